// File: rtl/mover_pkg.sv
// Shared types and constants for the block-move engine.
//   - state_t  : IDLE / READ / WRITE / FIN controller states
//   - WORD_W   : address and data width
//   - in_rom() : true when an address falls in the ROM window 0x0000-0x1FFF
package mover_pkg;

    localparam int WORD_W      = 16;
    localparam int ROM_SEL_MSB = 15;
    localparam int ROM_SEL_LSB = 13;
    localparam logic [ROM_SEL_MSB-ROM_SEL_LSB:0] ROM_SEL_VAL = 3'b000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } state_t;

    function automatic logic in_rom(input logic [WORD_W-1:0] addr);
        return (addr[ROM_SEL_MSB:ROM_SEL_LSB] == ROM_SEL_VAL);
    endfunction

endpackage

// File: rtl/mover_ptr.sv
// Purpose : 16-bit loadable up/down pointer that wraps modulo 2^16.
// Latency : load/step take effect on the next CLK edge; o_ptr_step is combinational.
// Backpr. : none; the controller decides when to load or step.
// Ports:
//   i_clk, i_rst            clock, async active-high reset
//   i_load, i_load_val      load a new start address (wins over step)
//   i_step, i_dec           advance by one, downwards when i_dec=1
//   o_ptr                   current pointer value
//   o_ptr_step              value the pointer takes on its next step
module mover_ptr
    import mover_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_load_val,
    input  logic              i_step,
    input  logic              i_dec,
    output logic [WORD_W-1:0] o_ptr,
    output logic [WORD_W-1:0] o_ptr_step
);

    logic [WORD_W-1:0] r_ptr;
    logic [WORD_W-1:0] w_ptr_step;

    // Plain modular arithmetic gives the required wrap in both directions.
    assign w_ptr_step = i_dec ? (r_ptr - WORD_W'(1)) : (r_ptr + WORD_W'(1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_load) begin
            r_ptr <= i_load_val;
        end else if (i_step) begin
            r_ptr <= w_ptr_step;
        end
    end

    assign o_ptr      = r_ptr;
    assign o_ptr_step = w_ptr_step;

endmodule

// File: rtl/mem_block_mover.sv
// Purpose : copies LEN 16-bit words SRC->DST over the memory port (one read, one write per word).
// Latency : 2*LEN+1 cycles from START to the DONE pulse; LEN=0 gives DONE the cycle after START.
// Backpr. : none; START is ignored while BUSY or DONE is high, memory must answer within the cycle.
// Ports:
//   CLK, RST                 clock, async active-high reset
//   START, SRC, DST, LEN, DEC  request and operands, latched when START is accepted
//   BUSY, DONE, ERR          status (ERR is sticky until the next accepted START)
//   M_ADDR, M_DIN, M_STO     memory request, all registered
//   M_DOUT                   memory read data, combinational from M_ADDR
// Build option: MOVER_ROM_GUARD_EN aborts the move with ERR instead of writing into 0x0000-0x1FFF.
module mem_block_mover
    import mover_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [WORD_W-1:0] SRC,
    input  logic [WORD_W-1:0] DST,
    input  logic [WORD_W-1:0] LEN,
    input  logic              DEC,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [WORD_W-1:0] M_ADDR,
    output logic [WORD_W-1:0] M_DIN,
    output logic              M_STO,
    input  logic [WORD_W-1:0] M_DOUT
);

    state_t            r_state;
    logic [WORD_W-1:0] r_cnt;
    logic              r_dec;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_din;
    logic              r_sto;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    state_t            w_state_nxt;
    logic [WORD_W-1:0] w_cnt_nxt;
    logic              w_dec_nxt;
    logic [WORD_W-1:0] w_addr_nxt;
    logic [WORD_W-1:0] w_din_nxt;
    logic              w_sto_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_err_nxt;
    logic              w_ptr_load;
    logic              w_ptr_step;
    logic              w_guard_hit;

    logic [WORD_W-1:0] w_src_ptr;
    logic [WORD_W-1:0] w_src_step;
    logic [WORD_W-1:0] w_dst_ptr;
    logic [WORD_W-1:0] w_dst_step;

    mover_ptr u_src_ptr (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_load     (w_ptr_load),
        .i_load_val (SRC),
        .i_step     (w_ptr_step),
        .i_dec      (r_dec),
        .o_ptr      (w_src_ptr),
        .o_ptr_step (w_src_step)
    );

    mover_ptr u_dst_ptr (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_load     (w_ptr_load),
        .i_load_val (DST),
        .i_step     (w_ptr_step),
        .i_dec      (r_dec),
        .o_ptr      (w_dst_ptr),
        .o_ptr_step (w_dst_step)
    );

    // Destination check made while reading, so a refused write never drives M_STO.
`ifdef MOVER_ROM_GUARD_EN
    assign w_guard_hit = in_rom(w_dst_ptr);
`else
    assign w_guard_hit = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dec   <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
            r_sto   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dec   <= w_dec_nxt;
            r_addr  <= w_addr_nxt;
            r_din   <= w_din_nxt;
            r_sto   <= w_sto_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Outputs are registered, so each branch computes what the next cycle shows:
    // the address for the coming READ is the source pointer after its step.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dec_nxt   = r_dec;
        w_addr_nxt  = r_addr;
        w_din_nxt   = r_din;
        w_sto_nxt   = 1'b0;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;
        w_ptr_load  = 1'b0;
        w_ptr_step  = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_busy_nxt = 1'b0;
                if (START) begin
                    w_ptr_load = 1'b1;
                    w_dec_nxt  = DEC;
                    w_cnt_nxt  = LEN;
                    w_err_nxt  = 1'b0;
                    if (LEN == '0) begin
                        w_state_nxt = FIN;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = READ;
                        w_busy_nxt  = 1'b1;
                        w_addr_nxt  = SRC;
                    end
                end
            end
            READ: begin
                if (w_guard_hit) begin
                    w_state_nxt = FIN;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_state_nxt = WRITE;
                    w_addr_nxt  = w_dst_ptr;
                    w_din_nxt   = M_DOUT;
                    w_sto_nxt   = 1'b1;
                end
            end
            WRITE: begin
                w_ptr_step = 1'b1;
                w_cnt_nxt  = r_cnt - WORD_W'(1);
                if (r_cnt == WORD_W'(1)) begin
                    w_state_nxt = FIN;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_state_nxt = READ;
                    w_addr_nxt  = w_src_step;
                end
            end
            FIN: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign BUSY   = r_busy;
    assign DONE   = r_done;
    assign ERR    = r_err;
    assign M_ADDR = r_addr;
    assign M_DIN  = r_din;
    assign M_STO  = r_sto;

    // Destination step value is not needed: WRITE addresses come from the unstepped pointer.
    logic w_unused;
    assign w_unused = ^w_dst_step;

endmodule

// File: tb/tb_mem_block_mover.sv
// Directed bench for mem_block_mover with a 64K-word memory model (ROM and RAM in one array).
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_mem_block_mover;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [15:0] SRC = '0;
    logic [15:0] DST = '0;
    logic [15:0] LEN = '0;
    logic        DEC = 1'b0;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [15:0] M_ADDR;
    logic [15:0] M_DIN;
    logic        M_STO;
    logic [15:0] M_DOUT;

    logic [15:0] mem [0:65535];
    logic        pl_we = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [15:0] pl_dat = '0;
    logic [15:0] addr_log [0:15];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    mem_block_mover dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .SRC    (SRC),
        .DST    (DST),
        .LEN    (LEN),
        .DEC    (DEC),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .ERR    (ERR),
        .M_ADDR (M_ADDR),
        .M_DIN  (M_DIN),
        .M_STO  (M_STO),
        .M_DOUT (M_DOUT)
    );

    // Memory: combinational read, write on the edge ending a store cycle.
    assign M_DOUT = mem[M_ADDR];
    always @(posedge CLK) begin
        if (M_STO)
            mem[M_ADDR] <= M_DIN;
        else if (pl_we)
            mem[pl_addr] <= pl_dat;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h, want 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        pl_addr = a;
        pl_dat  = d;
        pl_we   = 1'b1;
        tick();
        pl_we   = 1'b0;
    endtask

    // Issues START, then checks M_STO/BUSY/DONE in every cycle t0+1 .. t0+1+2*len
    // and logs M_ADDR of each memory cycle. Returns in the cycle after DONE.
    task automatic run_move(input logic [15:0] s, input logic [15:0] d,
                            input int len, input logic dn);
        SRC   = s;
        DST   = d;
        LEN   = 16'(len);
        DEC   = dn;
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int c = 1; c <= 2*len+1; c++) begin
            if (c <= 2*len) addr_log[c-1] = M_ADDR;
            chk($sformatf("sto_c%0d", c),  {15'd0, M_STO}, {15'd0, (c % 2 == 0) && (c <= 2*len)});
            chk($sformatf("busy_c%0d", c), {15'd0, BUSY},  {15'd0, (c < 2*len+1)});
            chk($sformatf("done_c%0d", c), {15'd0, DONE},  {15'd0, (c == 2*len+1)});
            tick();
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_addr", M_ADDR, 16'h0000);
        chk("rst_din",  M_DIN,  16'h0000);
        chk("rst_sto",  {15'd0, M_STO}, 16'd0);
        chk("rst_busy", {15'd0, BUSY},  16'd0);
        chk("rst_done", {15'd0, DONE},  16'd0);
        chk("rst_err",  {15'd0, ERR},   16'd0);
        RST = 1'b0;
        tick();

        // Ascending ROM -> RAM
        poke(16'h0000, 16'h1111);
        poke(16'h0001, 16'h2222);
        poke(16'h0002, 16'h3333);
        poke(16'h0003, 16'h4444);
        run_move(16'h0000, 16'h4000, 4, 1'b0);
        chk("asc_a0", addr_log[0], 16'h0000);
        chk("asc_a1", addr_log[1], 16'h4000);
        chk("asc_a2", addr_log[2], 16'h0001);
        chk("asc_a7", addr_log[7], 16'h4003);
        chk("asc_m0", mem[16'h4000], 16'h1111);
        chk("asc_m1", mem[16'h4001], 16'h2222);
        chk("asc_m2", mem[16'h4002], 16'h3333);
        chk("asc_m3", mem[16'h4003], 16'h4444);

        // Empty move
        poke(16'h5678, 16'h0EEE);
        run_move(16'h1234, 16'h5678, 0, 1'b0);
        chk("empty_mem", mem[16'h5678], 16'h0EEE);
        chk("empty_idle_done", {15'd0, DONE}, 16'd0);

        // Descending overlapping move
        poke(16'h4000, 16'hAAAA);
        poke(16'h4001, 16'hBBBB);
        poke(16'h4002, 16'hCCCC);
        poke(16'h4003, 16'h0000);
        run_move(16'h4002, 16'h4003, 3, 1'b1);
        chk("dsc_a0", addr_log[0], 16'h4002);
        chk("dsc_a1", addr_log[1], 16'h4003);
        chk("dsc_a5", addr_log[5], 16'h4001);
        chk("dsc_m0", mem[16'h4000], 16'hAAAA);
        chk("dsc_m1", mem[16'h4001], 16'hAAAA);
        chk("dsc_m2", mem[16'h4002], 16'hBBBB);
        chk("dsc_m3", mem[16'h4003], 16'hCCCC);

        // Wrap-around of the source pointer
        poke(16'hFFFF, 16'h5A5A);
        poke(16'h0000, 16'h1111);
        poke(16'h8000, 16'h0000);
        poke(16'h8001, 16'h0000);
        run_move(16'hFFFF, 16'h8000, 2, 1'b0);
        chk("wrap_a0", addr_log[0], 16'hFFFF);
        chk("wrap_a1", addr_log[1], 16'h8000);
        chk("wrap_a2", addr_log[2], 16'h0000);
        chk("wrap_a3", addr_log[3], 16'h8001);
        chk("wrap_m0", mem[16'h8000], 16'h5A5A);
        chk("wrap_m1", mem[16'h8001], 16'h1111);

        // Destination in the ROM window
        poke(16'h4000, 16'h7001);
        poke(16'h4001, 16'h7002);
        poke(16'h1FFF, 16'h0BAD);
        poke(16'h2000, 16'h0BAD);
`ifdef MOVER_ROM_GUARD_EN
        SRC = 16'h4000; DST = 16'h1FFF; LEN = 16'd2; DEC = 1'b0;
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("grd_sto1",  {15'd0, M_STO}, 16'd0);
        chk("grd_busy1", {15'd0, BUSY},  16'd1);
        tick();
        chk("grd_done",  {15'd0, DONE},  16'd1);
        chk("grd_err",   {15'd0, ERR},   16'd1);
        chk("grd_sto2",  {15'd0, M_STO}, 16'd0);
        chk("grd_busy2", {15'd0, BUSY},  16'd0);
        tick();
        chk("grd_err_sticky", {15'd0, ERR}, 16'd1);
        chk("grd_m0", mem[16'h1FFF], 16'h0BAD);
        chk("grd_m1", mem[16'h2000], 16'h0BAD);
`else
        run_move(16'h4000, 16'h1FFF, 2, 1'b0);
        chk("grd_a1", addr_log[1], 16'h1FFF);
        chk("grd_a3", addr_log[3], 16'h2000);
        chk("grd_m0", mem[16'h1FFF], 16'h7001);
        chk("grd_m1", mem[16'h2000], 16'h7002);
        chk("grd_err", {15'd0, ERR}, 16'd0);
`endif
        // Accepted START clears ERR
        run_move(16'h0000, 16'h0000, 0, 1'b0);
        chk("err_clear", {15'd0, ERR}, 16'd0);

        // START while busy is ignored
        poke(16'h4000, 16'h0A01);
        poke(16'h4001, 16'h0A02);
        poke(16'h5000, 16'h0000);
        poke(16'h5001, 16'h0000);
        poke(16'h7000, 16'h0777);
        SRC = 16'h4000; DST = 16'h5000; LEN = 16'd2; DEC = 1'b0;
        START = 1'b1;
        tick();
        START = 1'b0;                                   // t0+1
        chk("bsy_a1", M_ADDR, 16'h4000);
        tick();                                         // t0+2
        chk("bsy_a2", M_ADDR, 16'h5000);
        tick();                                         // t0+3
        SRC = 16'h6000; DST = 16'h7000; LEN = 16'd5; DEC = 1'b1;
        START = 1'b1;
        chk("bsy_a3", M_ADDR, 16'h4001);
        tick();                                         // t0+4
        START = 1'b0;
        chk("bsy_a4",   M_ADDR, 16'h5001);
        chk("bsy_sto4", {15'd0, M_STO}, 16'd1);
        tick();                                         // t0+5
        chk("bsy_done5", {15'd0, DONE}, 16'd1);
        tick();                                         // t0+6
        chk("bsy_done6", {15'd0, DONE}, 16'd0);
        tick();
        chk("bsy_busy7", {15'd0, BUSY}, 16'd0);
        chk("bsy_m0", mem[16'h5000], 16'h0A01);
        chk("bsy_m1", mem[16'h5001], 16'h0A02);
        chk("bsy_m2", mem[16'h7000], 16'h0777);

        // Reset during the WRITE of word 1
        poke(16'h4000, 16'h1234);
        poke(16'h4001, 16'h5678);
        poke(16'h6000, 16'h0000);
        poke(16'h6001, 16'hDEAD);
        SRC = 16'h6000; DST = 16'h6000; LEN = 16'd0;
        SRC = 16'h4000; LEN = 16'd2; DEC = 1'b0;
        START = 1'b1;
        tick();
        START = 1'b0;                                   // t0+1
        tick();
        tick();
        tick();                                         // t0+4
        chk("rmid_addr", M_ADDR, 16'h6001);
        chk("rmid_din",  M_DIN,  16'h5678);
        chk("rmid_sto",  {15'd0, M_STO}, 16'd1);
        #3;
        RST = 1'b1;
        #1;
        chk("rmid_sto_async", {15'd0, M_STO}, 16'd0);
        chk("rmid_addr0",     M_ADDR, 16'h0000);
        chk("rmid_din0",      M_DIN,  16'h0000);
        chk("rmid_busy0",     {15'd0, BUSY}, 16'd0);
        chk("rmid_done0",     {15'd0, DONE}, 16'd0);
        tick();
        RST = 1'b0;
        tick();
        tick();
        chk("rmid_idle_busy", {15'd0, BUSY},  16'd0);
        chk("rmid_idle_sto",  {15'd0, M_STO}, 16'd0);
        chk("rmid_m0", mem[16'h6000], 16'h1234);
        chk("rmid_m1", mem[16'h6001], 16'hDEAD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
